// File: rtl/frac_clock_pkg.sv
// Shared defaults and types for the fractional clock-enable generator.
// A ratio is div/mul; a zero divisor marks a disabled channel.
package frac_clock_pkg;

  localparam int FCG_W    = 32;
  localparam int FCG_N_CH = 4;
  localparam int FCG_CH_W = (FCG_N_CH > 1) ? $clog2(FCG_N_CH) : 1;

  typedef struct packed {
    logic [FCG_W-1:0] div;
    logic [FCG_W-1:0] mul;
  } ratio_t;

  localparam logic [FCG_W-1:0] DISABLED_DIV = {FCG_W{1'b0}};

endpackage

// File: rtl/frac_div_ch.sv
// One fractional divider channel: phase accumulator with shadow/active ratio.
// The shadow ratio is applied only on a tick cycle, so periods are never cut short.
module frac_div_ch
  import frac_clock_pkg::*;
#(
  parameter int W = FCG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_div,
  input  logic [W-1:0] load_mul,
  input  logic         sync,
  output logic         tick,
  output logic         clk_out,
  output logic         pending,
  output logic         cfg_err
);

  logic [W-1:0] acc_r, act_div_r, act_mul_r, shd_div_r, shd_mul_r;
  logic         tick_r, clk_out_r, pending_r, cfg_err_r;

  logic [W-1:0] acc_s, act_div_s, act_mul_s, shd_div_s, shd_mul_s;
  logic         tick_s, clk_out_s, pending_s, cfg_err_s;
  logic [W:0]   sum_s, diff_s;
  logic         enabled_s, over_s, fire_s;

  function automatic logic ratio_bad(input logic [W-1:0] d, input logic [W-1:0] m);
    return (d != W'(DISABLED_DIV)) && (m > d);
  endfunction

  // Next-state: accumulate, tick, apply shadow on tick or when disabled, sync realign.
  always_comb begin
    sum_s     = {1'b0, acc_r} + {1'b0, act_mul_r};
    diff_s    = sum_s - {1'b0, act_div_r};
    enabled_s = (act_div_r != W'(DISABLED_DIV));
    over_s    = enabled_s && (act_mul_r > act_div_r);
    fire_s    = enabled_s && (over_s || (sum_s >= {1'b0, act_div_r}));

    acc_s     = acc_r;
    act_div_s = act_div_r;
    act_mul_s = act_mul_r;
    shd_div_s = shd_div_r;
    shd_mul_s = shd_mul_r;
    tick_s    = 1'b0;
    clk_out_s = clk_out_r;
    pending_s = pending_r;
    cfg_err_s = cfg_err_r | over_s;

    if (sync) begin
      acc_s     = {W{1'b0}};
      clk_out_s = 1'b0;
      pending_s = 1'b0;
      if (load) begin
        act_div_s = load_div;
        act_mul_s = load_mul;
        shd_div_s = load_div;
        shd_mul_s = load_mul;
        cfg_err_s = ratio_bad(load_div, load_mul);
      end else if (pending_r) begin
        act_div_s = shd_div_r;
        act_mul_s = shd_mul_r;
        cfg_err_s = ratio_bad(shd_div_r, shd_mul_r);
      end else begin
        cfg_err_s = cfg_err_r;
      end
    end else begin
      if (!enabled_s) begin
        acc_s = {W{1'b0}};
      end else if (fire_s) begin
        tick_s    = 1'b1;
        clk_out_s = ~clk_out_r;
        acc_s     = over_s ? {W{1'b0}} : diff_s[W-1:0];
      end else begin
        acc_s = sum_s[W-1:0];
      end

      if ((!enabled_s || fire_s) && pending_r) begin
        act_div_s = shd_div_r;
        act_mul_s = shd_mul_r;
        pending_s = 1'b0;
        cfg_err_s = ratio_bad(shd_div_r, shd_mul_r);
      end else begin
        pending_s = pending_r;
      end

      // A write landing on an apply edge starts a fresh pending shadow.
      if (load) begin
        shd_div_s = load_div;
        shd_mul_s = load_mul;
        pending_s = 1'b1;
      end else begin
        shd_div_s = shd_div_r;
        shd_mul_s = shd_mul_r;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= {W{1'b0}};
      act_div_r <= {W{1'b0}};
      act_mul_r <= {W{1'b0}};
      shd_div_r <= {W{1'b0}};
      shd_mul_r <= {W{1'b0}};
      tick_r    <= 1'b0;
      clk_out_r <= 1'b0;
      pending_r <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      acc_r     <= acc_s;
      act_div_r <= act_div_s;
      act_mul_r <= act_mul_s;
      shd_div_r <= shd_div_s;
      shd_mul_r <= shd_mul_s;
      tick_r    <= tick_s;
      clk_out_r <= clk_out_s;
      pending_r <= pending_s;
      cfg_err_r <= cfg_err_s;
    end
  end

  assign tick    = tick_r;
  assign clk_out = clk_out_r;
  assign pending = pending_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: rtl/frac_clock_gen.sv
// Multi-channel fractional clock-enable generator.
// Decodes the config write to per-channel load strobes; indices beyond N_CH match nothing.
module frac_clock_gen
  import frac_clock_pkg::*;
#(
  parameter int N_CH = FCG_N_CH,
  parameter int W    = FCG_W,
  parameter int CH_W = FCG_CH_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_div,
  input  logic [W-1:0]    cfg_mul,
  input  logic            sync,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] cfg_err
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic load_s;
    assign load_s = cfg_we && (cfg_ch == CH_W'(gi));

    frac_div_ch #(
      .W(W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .load_div (cfg_div),
      .load_mul (cfg_mul),
      .sync     (sync),
      .tick     (tick[gi]),
      .clk_out  (clk_out[gi]),
      .pending  (pending[gi]),
      .cfg_err  (cfg_err[gi])
    );
  end

endmodule

// File: tb/tb_frac_clock_gen.sv
// Directed bench for frac_clock_gen: hand-computed tick positions per scenario.
module tb_frac_clock_gen;
  import frac_clock_pkg::*;

  localparam int N_CH = 4;
  localparam int W    = 32;
  localparam int CH_W = 2;

  logic            clk;
  logic            rst_n;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [W-1:0]    cfg_div;
  logic [W-1:0]    cfg_mul;
  logic            sync;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] clk_out;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] cfg_err;

  int checks   = 0;
  int failures = 0;

  frac_clock_gen #(.N_CH(N_CH), .W(W), .CH_W(CH_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mul (cfg_mul),
    .sync    (sync),
    .tick    (tick),
    .clk_out (clk_out),
    .pending (pending),
    .cfg_err (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; returns at the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_cfg(input int ch, input int dv, input int ml);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = W'(dv);
    cfg_mul = W'(ml);
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic sync_cfg(input int ch, input int dv, input int ml);
    sync = 1'b1;
    write_cfg(ch, dv, ml);
    sync = 1'b0;
  endtask

  initial begin
    int cnt;
    int pos[4];
    int np;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mul = '0; sync = 1'b0;
    step(); step();
    check_val("rst_tick", tick, 4'h0);
    check_val("rst_clk_out", clk_out, 4'h0);
    check_val("rst_pending", pending, 4'h0);
    check_val("rst_cfg_err", cfg_err, 4'h0);
    rst_n = 1'b1;
    step(); step();
    check_val("idle_tick", tick, 4'h0);

    // ch0 div=3 mul=1 from disabled
    write_cfg(0, 3, 1);
    check_val("t1_pending_set", pending[0], 1'b1);
    step();
    check_val("t1_pending_clr", pending[0], 1'b0);
    check_val("t1_tick_apply", tick[0], 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val($sformatf("t1_tick_k%0d", k), tick[0], (k % 3 == 0));
      check_val($sformatf("t1_clkout_k%0d", k), clk_out[0], ((k / 3) % 2));
    end

    // ch1 div=10 mul=3: 30 ticks per 100, 300 per 1000, spacing 4,3,3
    write_cfg(1, 10, 3);
    step();
    cnt = 0; np = 0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (tick[1]) begin
        cnt++;
        if (np < 4) begin pos[np] = k; np++; end
      end
      if (k == 100) check_val("t2_cnt100", cnt, 30);
    end
    check_val("t2_cnt1000", cnt, 300);
    check_val("t2_pos0", pos[0], 4);
    check_val("t2_pos1", pos[1], 7);
    check_val("t2_pos2", pos[2], 10);
    check_val("t2_pos3", pos[3], 14);

    // ch0 div=4 mul=1, reprogram to div=2 mid-period
    sync_cfg(0, 4, 1);
    check_val("t3_sync_clk_out", clk_out, 4'h0);
    check_val("t3_sync_pending", pending[0], 1'b0);
    step(); step();
    write_cfg(0, 2, 1);
    check_val("t3_pending_mid", pending[0], 1'b1);
    check_val("t3_tick_mid", tick[0], 1'b0);
    step();
    check_val("t3_tick_old_end", tick[0], 1'b1);
    check_val("t3_pending_clr", pending[0], 1'b0);
    check_val("t3_clkout_hi", clk_out[0], 1'b1);
    step();
    check_val("t3_tick_gap", tick[0], 1'b0);
    check_val("t3_clkout_hold", clk_out[0], 1'b1);
    step();
    check_val("t3_tick_new", tick[0], 1'b1);
    check_val("t3_clkout_lo", clk_out[0], 1'b0);

    // ch2 mul > div, then legal rewrite
    write_cfg(2, 5, 7);
    check_val("t4_err_before", cfg_err[2], 1'b0);
    check_val("t4_pending", pending[2], 1'b1);
    step();
    check_val("t4_err_set", cfg_err[2], 1'b1);
    step();
    check_val("t4_tick_a", tick[2], 1'b1);
    step();
    check_val("t4_tick_b", tick[2], 1'b1);
    write_cfg(2, 5, 1);
    check_val("t4_err_sticky", cfg_err[2], 1'b1);
    step();
    check_val("t4_err_clr", cfg_err[2], 1'b0);
    check_val("t4_pending_clr", pending[2], 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check_val($sformatf("t4_tick_k%0d", k), tick[2], (k % 5 == 0));
    end

    // sync with simultaneous write to ch3
    write_cfg(0, 3, 1);
    write_cfg(1, 5, 2);
    for (int k = 0; k < 7; k++) step();
    check_val("t5_pre_pending", pending, 4'h0);
    sync_cfg(3, 2, 1);
    check_val("t5_clk_out", clk_out, 4'h0);
    check_val("t5_tick", tick, 4'h0);
    check_val("t5_pending", pending, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_val($sformatf("t5_ch0_k%0d", k), tick[0], (k == 3));
      check_val($sformatf("t5_ch1_k%0d", k), tick[1], (k == 3));
      check_val($sformatf("t5_ch3_k%0d", k), tick[3], (k == 2));
    end

    // async reset between edges
    write_cfg(2, 5, 7);
    write_cfg(1, 7, 1);
    check_val("t6_pre_pending", pending[1], 1'b1);
    check_val("t6_pre_err", cfg_err[2], 1'b1);
    check_val("t6_pre_tick", tick[2], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_tick", tick, 4'h0);
    check_val("t6_async_clk_out", clk_out, 4'h0);
    check_val("t6_async_pending", pending, 4'h0);
    check_val("t6_async_cfg_err", cfg_err, 4'h0);
    step(); step();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick != 4'h0) cnt++;
    end
    check_val("t6_no_ticks", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frac_clock_gen.md
Name: frac_clock_gen

Overview:
- Multi-channel fractional clock-enable generator; successor to the single-channel integer divider.
- Each channel runs a phase accumulator, so it produces tick pulses at the exact average rate mul/div of clk with no cumulative drift.
- Each channel also produces a toggled square output at half the tick rate.
- Per-channel ratios are reprogrammed at runtime through a write port, glitch-free, and all channels can be realigned together.

Parameters:
N_CH, 4, number of independent channels
W, 32, width of div, mul and accumulator
CH_W, 2, width of channel index (clog2(N_CH), min 1)

Ports:
clk  in  1  sole clock, rising-edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  write strobe for one channel's ratio
cfg_ch  in  CH_W  target channel of write
cfg_div  in  W  denominator; 0 = channel disabled
cfg_mul  in  W  numerator (increment per clk)
sync  in  1  one-cycle pulse: realign all channels
tick  out  N_CH  one-cycle enable pulse per channel
clk_out  out  N_CH  toggles on every tick of that channel
pending  out  N_CH  shadow ratio written, not yet active
cfg_err  out  N_CH  sticky: active mul > div

Behaviour:
- Reset (async assert, sync release): acc=0, active div=0, active mul=0, shadow=0; tick=0, clk_out=0, pending=0, cfg_err=0.
- Per channel per cycle, with active D,M and sum S = acc + M computed at W+1 bits:
  - D==0: disabled; acc held 0, tick=0, clk_out holds.
  - D!=0, S >= D: tick=1 next cycle (registered output, latency 1); acc <= S - D (remainder kept, never cleared); clk_out toggles in the same cycle tick rises.
  - Else: acc <= S[W-1:0], tick=0.
- Long-run tick rate is exactly M/D per clk. Over any window of D cycles, tick count is floor or ceil of M.
- M==0 with D!=0: never ticks.
- M > D: tick every cycle, acc <= 0, cfg_err set (sticky until reset or a legal write to that channel).
- M == D: tick every cycle; clk_out = clk/2.
- Config write (cfg_we=1):
  - cfg_div/cfg_mul go to that channel's shadow; pending=1.
  - Shadow becomes active on the channel's next tick cycle: the update is applied together with the acc remainder update, and the new ratio governs the following cycle. No partial period, no glitch on clk_out.
  - If the channel is currently disabled (D==0), shadow is applied the next cycle with acc=0.
  - pending clears in the cycle the shadow is applied.
  - A second write before application overwrites the shadow; the last write wins.
  - cfg_ch >= N_CH: write ignored.
- sync=1, all channels at the next edge:
  - acc=0, clk_out=0, tick=0.
  - Any pending shadow becomes active and pending clears.
  - Channels restart in phase, so each first tick after sync arrives after exactly ceil(D/M) cycles.
- sync and cfg_we in the same cycle: sync takes effect, then the written values go directly to active for that channel (acc=0, pending=0).
- Reset mid-operation clears all state immediately, including shadows and pending; no tick is emitted during or in the cycle after reset release.

Decomposition:
- Package frac_clock_pkg holds:
  - default W, N_CH, derived CH_W;
  - ratio struct {div, mul} of W bits each;
  - constant DISABLED_DIV = 0.
- Sub-module frac_div_ch, one channel: accumulator, shadow/active ratio registers, pending and cfg_err flags, tick/clk_out registers. Inputs: load strobe, shadow data, sync.
- Top level instantiates N_CH copies in a generate loop and decodes cfg_ch to per-channel load strobes.

Test Plan:
- Reset release; ch0 write div=3, mul=1 -> pending[0]=1 for 1 cycle, then tick[0] every 3rd cycle; clk_out[0] period 6 clk.
- ch1 div=10, mul=3 for 100 cycles -> exactly 30 ticks; tick spacing pattern 4,3,3 repeating (remainders 3,6,9,2,5,8,1,4,7,0); no drift at cycle 1000 (300 ticks).
- ch0 running div=4, mul=1; write div=2, mul=1 mid-period -> old period completes, tick pulse rises once, next tick 2 cycles later; pending drops in the tick cycle; clk_out has no glitch.
- ch2 div=5, mul=7 -> cfg_err[2]=1, tick[2] high every cycle; then write div=5, mul=1 -> cfg_err[2] clears, tick every 5 cycles.
- Channels at div=3/mul=1 and div=5/mul=2 running out of phase; pulse sync together with cfg_we to ch3 (div=2, mul=1) -> all acc=0 and clk_out=0; ch3 active immediately; first ticks land 3, 3, 2 cycles after sync respectively.
- Assert rst_n=0 asynchronously mid-period between clk edges -> tick, clk_out, pending, cfg_err drop without waiting for a clk edge; after release, no ticks until a new config write (div=0).
